ps2_key_rx: RTL and testbench
=============================

# ps2_key_rx

Receiver that turns the raw PS/2 keyboard clock/data lines into the 65-bit `ps2_key` event word that core key decoders consume. It filters and deserializes 11-bit device-to-host frames, collects prefix bytes (E0, F0, E1) and multi-part sequences into one event, and toggles bit 64 once per completed key event. It sits between the keyboard pins and any core logic that decodes `ps2_key` edge-to-edge.

## Interface
- `FILTER`, default 8: number of consecutive `clk_sys` cycles a synchronized PS/2 line must hold a new level before the filtered line changes.
- `TIMEOUT`, default 48000: `clk_sys` cycles without a filtered clock falling edge before a partial frame is aborted (2 ms at 24 MHz).
- `clk_sys` input, 1 bit: system clock; all logic runs on its rising edge.
- `RESET_N` input, 1 bit: reset, asynchronous and active-low.
- `ps2_clk` input, 1 bit: raw PS/2 clock, asynchronous.
- `ps2_data` input, 1 bit: raw PS/2 data, asynchronous.
- `ps2_key` output, 65 bits:
  - [64]: event toggle.
  - [63:0]: byte history of the event, newest byte in [7:0].
- `frame_err` output, 1 bit: one-cycle pulse on a parity error, stop-bit error, or timeout abort.

## Operation
**Input conditioning**
- Each line passes through a 2-FF synchronizer, then a stability filter.
- The filter uses a counter that reloads on any mismatch. The filtered level updates when the counter reaches `FILTER`.
- Filtered lines reset to 1.

**Frame FSM**
- States and transitions:
  - IDLE → DATA when start bit = 0 is sampled. A start bit = 1 is ignored and the FSM stays in IDLE.
  - DATA: 8 bits, LSB first → PARITY → STOP → IDLE.
- Data is sampled on each filtered-clock falling edge.
- The frame is valid when the sum of the 8 data bits plus the parity bit is odd and stop = 1. Otherwise `frame_err` pulses and the byte is dropped.
- Timeout: in any state other than IDLE, the timeout counter counts cycles since the last falling edge. On reaching `TIMEOUT` it returns the FSM to IDLE, pulses `frame_err`, and leaves the event accumulator untouched.

**Event accumulator**
- Holds a 64-bit history `hist` and a 3-bit `e1_cnt`.
- On each valid byte B: `hist <= {hist[55:0], B}`. Bytes older than 8 are lost.
- A byte completes an event unless one of these holds:
  - B ∈ {E0, F0}.
  - B = E1, which loads `e1_cnt = 7`.
  - `e1_cnt` ≠ 0. Each such byte decrements `e1_cnt`, and the byte that takes it to 0 completes the event.
  - The accumulated tail is E0 12 (PrtScr press, part 1).
  - The accumulated tail is E0 F0 7C (PrtScr release, part 1).
- On event completion:
  - `ps2_key[63:0] <= hist`, including B.
  - `ps2_key[64]` inverts.
  - `hist` is cleared on the following cycle, so the next event starts from zero.
- Resulting encodings:
  - Plain press: [15:8] ≠ F0.
  - Release: [15:8] = F0.
  - Extended release: [23:16] = E0.
  - PrtScr and Pause leave [63:24] ≠ 0.

**Reset values**
- `ps2_key = 0`, `frame_err = 0`.
- FSM in IDLE, `hist = 0`, `e1_cnt = 0`, all counters 0.

## Timing
- Reset clears all state immediately. This holds mid-frame and mid-sequence: a partial byte or prefix is discarded, with no event and no `frame_err`.
- Filtered line delay:
  - Input change to synchronized line: 2 cycles.
  - Filtered line settles `FILTER` cycles after the synchronized line.
- Each falling edge is detected 1 cycle after the filtered clock falls.
- The completed byte is checked in the cycle after the stop-bit edge is detected.
- `ps2_key` updates and `frame_err` pulses in the same cycle as that check.
- Fastest legal PS/2 clock (16.7 kHz) vs 24 MHz `clk_sys`: ≥700 cycles per bit, so no back-to-back hazard exists.
- A timeout abort and a falling edge in the same cycle: the abort wins, and the edge is ignored.
- `frame_err` is never high for more than 1 cycle per fault.

## Test plan
- Frame 1C (parity 0, stop 1), starting from reset → `ps2_key[63:0]=0x1C`, bit 64 toggles 0→1, `frame_err` stays 0.
- Frames F0, 1C → one event: [15:8]=F0, [7:0]=1C, bit 64 toggles once.
- Frames E0, F0, 75 → one event: [23:0]=E0F075. A following 1C → [63:0]=0x1C, confirming history was cleared.
- PrtScr press E0 12 E0 7C → one event with [31:0]=E012E07C. Pause E1 14 77 E1 F0 14 F0 77 → one event with [63:0]=E11477E1F014F077, bit 64 toggling once per sequence.
- Error cases:
  - Frame 1C with bad parity → `frame_err` 1-cycle pulse, `ps2_key` unchanged.
  - Stop bit 0 → the same response.
  - 5 bits sent followed by an idle of `TIMEOUT` cycles → `frame_err` pulse, FSM back in IDLE, next valid 1C decodes correctly.
- `RESET_N` asserted after E0 plus 4 bits of the next frame → outputs 0. After release, frame 75 → [63:0]=0x75 with no E0 in the history.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: conditions the raw clock/data lines, deserializes
// device-to-host frames and assembles prefix/multi-byte sequences into one ps2_key event.
module ps2_key_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 48000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [64:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CHECK
    } state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_filt_q, dat_filt_q;
    logic [FW-1:0] clk_cnt_q, dat_cnt_q;
    logic          clk_prev_q, fall_q;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          par_q, stop_q;
    logic [TW-1:0] tmo_q;
    logic [63:0]   hist_q;
    logic [2:0]    e1_cnt_q;
    logic          clr_q;
    logic [64:0]   key_q;
    logic          err_q;

    logic [63:0]   hist_d;
    logic [2:0]    e1_cnt_d;
    logic          done_d;
    logic          frame_ok;

    assign ps2_key   = key_q;
    assign frame_err = err_q;

    // Synchronizers and stability filters; the filtered level only moves after
    // FILTER consecutive cycles of disagreement with the synchronized line.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_cnt_q  <= '0;
            dat_cnt_q  <= '0;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};

            if (clk_sync_q[1] == clk_filt_q) begin
                clk_cnt_q <= '0;
            end else if (clk_cnt_q == FW'(FILTER - 1)) begin
                clk_filt_q <= clk_sync_q[1];
                clk_cnt_q  <= '0;
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end

            if (dat_sync_q[1] == dat_filt_q) begin
                dat_cnt_q <= '0;
            end else if (dat_cnt_q == FW'(FILTER - 1)) begin
                dat_filt_q <= dat_sync_q[1];
                dat_cnt_q  <= '0;
            end else begin
                dat_cnt_q <= dat_cnt_q + 1'b1;
            end

            clk_prev_q <= clk_filt_q;
            fall_q     <= clk_prev_q & ~clk_filt_q;
        end
    end

    assign hist_d   = {hist_q[55:0], shreg_q};
    assign frame_ok = (^{shreg_q, par_q}) & stop_q;

    // Decide whether the byte just received closes the current key event.
    always_comb begin
        e1_cnt_d = e1_cnt_q;
        done_d   = 1'b0;
        if (e1_cnt_q != 3'd0) begin
            e1_cnt_d = e1_cnt_q - 3'd1;
            done_d   = (e1_cnt_q == 3'd1);
        end else if (shreg_q == 8'hE1) begin
            e1_cnt_d = 3'd7;
        end else if (shreg_q == 8'hE0 || shreg_q == 8'hF0) begin
            done_d = 1'b0;
        end else if (hist_d[15:0] == 16'hE012 || hist_d[23:0] == 24'hE0F07C) begin
            done_d = 1'b0;
        end else begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            tmo_q     <= '0;
            hist_q    <= '0;
            e1_cnt_q  <= '0;
            clr_q     <= 1'b0;
            key_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (clr_q) begin
                hist_q <= '0;
                clr_q  <= 1'b0;
            end

            // An expiring timeout takes priority over a coincident clock edge.
            if (state_q != S_IDLE && state_q != S_CHECK && tmo_q == TW'(TIMEOUT - 1)) begin
                state_q <= S_IDLE;
                tmo_q   <= '0;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tmo_q <= '0;
                        if (fall_q && !dat_filt_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        if (fall_q) begin
                            tmo_q     <= '0;
                            shreg_q   <= {dat_filt_q, shreg_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (fall_q) begin
                            tmo_q   <= '0;
                            par_q   <= dat_filt_q;
                            state_q <= S_STOP;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (fall_q) begin
                            tmo_q   <= '0;
                            stop_q  <= dat_filt_q;
                            state_q <= S_CHECK;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        state_q <= S_IDLE;
                        tmo_q   <= '0;
                        if (frame_ok) begin
                            hist_q   <= hist_d;
                            e1_cnt_q <= e1_cnt_d;
                            if (done_d) begin
                                key_q <= {~key_q[64], hist_d};
                                clr_q <= 1'b1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: table of key-event byte sequences plus
// hand-written parity, stop-bit, timeout and mid-sequence reset cases.
module tb_ps2_key_rx;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 2000;

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [64:0] ps2_key;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int evt_cnt = 0;
    int err_cnt = 0;
    int wide_cnt = 0;
    logic key64_prev = 1'b0;
    logic err_prev = 1'b0;

    ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys  (clk_sys),
        .RESET_N  (RESET_N),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        key64_prev <= ps2_key[64];
        err_prev   <= frame_err;
        if (RESET_N && ps2_key[64] != key64_prev) evt_cnt <= evt_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (frame_err && err_prev) wide_cnt <= wide_cnt + 1;
    end

    typedef struct {
        string       name;
        int          n;
        logic [63:0] seq;
        logic [63:0] exp;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(20);
        ps2_clk = 1'b0;
        cyc(40);
        ps2_clk = 1'b1;
        cyc(20);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(stop_bit);
        ps2_data = 1'b1;
        cyc(40);
    endtask

    initial begin
        logic        t0;
        int          e0, r0;
        logic [64:0] k0;

        vt[0] = '{"press_1C",      1, 64'h1C,               64'h1C};
        vt[1] = '{"release_1C",    2, 64'hF01C,             64'hF01C};
        vt[2] = '{"ext_rel_75",    3, 64'hE0F075,           64'hE0F075};
        vt[3] = '{"hist_cleared",  1, 64'h1C,               64'h1C};
        vt[4] = '{"prtscr_press",  4, 64'hE012E07C,         64'hE012E07C};
        vt[5] = '{"pause",         8, 64'hE11477E1F014F077, 64'hE11477E1F014F077};
        vt[6] = '{"prtscr_rel",    6, 64'hE0F07CE0F012,     64'hE0F07CE0F012};

        cyc(3);
        @(negedge clk_sys);
        chk("reset_key", ps2_key, 65'h0);
        chk("reset_err", {64'h0, frame_err}, 65'h0);
        RESET_N = 1'b1;
        cyc(20);

        for (int v = 0; v < 7; v++) begin
            @(negedge clk_sys);
            t0 = ps2_key[64];
            e0 = evt_cnt;
            r0 = err_cnt;
            for (int i = 0; i < vt[v].n; i++)
                send_frame(vt[v].seq[8*(vt[v].n-1-i) +: 8], 1'b0, 1'b1);
            @(negedge clk_sys);
            chk({vt[v].name, "_key"}, {1'b0, ps2_key[63:0]}, {1'b0, vt[v].exp});
            chk({vt[v].name, "_tog"}, {64'h0, ps2_key[64]}, {64'h0, ~t0});
            chk({vt[v].name, "_events"}, 65'(evt_cnt - e0), 65'd1);
            chk({vt[v].name, "_noerr"}, 65'(err_cnt - r0), 65'd0);
        end

        // Bad parity, then bad stop bit: one error pulse each, key untouched.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_sys);
            k0 = ps2_key;
            r0 = err_cnt;
            e0 = evt_cnt;
            if (k == 0) send_frame(8'h1C, 1'b1, 1'b1);
            else        send_frame(8'h1C, 1'b0, 1'b0);
            @(negedge clk_sys);
            chk(k == 0 ? "parity_err_cnt" : "stop_err_cnt", 65'(err_cnt - r0), 65'd1);
            chk(k == 0 ? "parity_key" : "stop_key", ps2_key, k0);
            chk(k == 0 ? "parity_noevt" : "stop_noevt", 65'(evt_cnt - e0), 65'd0);
        end

        // Partial frame abandoned: start + 4 data bits then silence.
        @(negedge clk_sys);
        k0 = ps2_key;
        r0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        cyc(TIMEOUT + 100);
        @(negedge clk_sys);
        chk("timeout_err_cnt", 65'(err_cnt - r0), 65'd1);
        chk("timeout_key", ps2_key, k0);
        send_frame(8'h1C, 1'b0, 1'b1);
        @(negedge clk_sys);
        chk("after_timeout_key", ps2_key, {~k0[64], 64'h1C});
        chk("after_timeout_noerr", 65'(err_cnt - r0), 65'd1);

        // Reset in the middle of an E0-prefixed sequence.
        send_frame(8'hE0, 1'b0, 1'b1);
        r0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b0;
        cyc(5);
        RESET_N = 1'b0;
        cyc(3);
        @(negedge clk_sys);
        chk("midreset_key", ps2_key, 65'h0);
        chk("midreset_err", {64'h0, frame_err}, 65'h0);
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        cyc(5);
        RESET_N = 1'b1;
        cyc(50);
        send_frame(8'h75, 1'b0, 1'b1);
        @(negedge clk_sys);
        chk("postreset_key", ps2_key, {1'b1, 64'h75});
        chk("postreset_noerr", 65'(err_cnt - r0), 65'd0);

        chk("err_pulse_width", 65'(wide_cnt), 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
